// File: rtl/sync_fifo_ld_if.sv
// FIFO port pair between host (master) and FIFO device (slave).
// SYNC_FIFO_ERR_FLAGS_EN adds the sticky ovf/udf error flags.
interface sync_fifo_ld_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIFO_SIZE = 4096
);
    localparam int unsigned LOAD_W = $clog2(FIFO_SIZE) + 1;

    logic              wr;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [LOAD_W-1:0] wr_load;
    logic              rd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic [LOAD_W-1:0] rd_load;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic              ovf;
    logic              udf;
`endif

    modport master (
        output wr, output wr_data, output rd,
        input  full, input wr_load, input rd_data, input rd_valid,
        input  empty, input rd_load
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , input ovf, input udf
`endif
    );

    modport slave (
        input  wr, input wr_data, input rd,
        output full, output wr_load, output rd_data, output rd_valid,
        output empty, output rd_load
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , output ovf, output udf
`endif
    );
endinterface

// File: rtl/sync_fifo_ld.sv
// Single-clock FIFO with registered read port, registered flags and word-count loads.
// SYNC_FIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags.
module sync_fifo_ld #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIFO_SIZE = 4096
) (
    input logic           clk,
    input logic           rst,
    sync_fifo_ld_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_SIZE);
    localparam int unsigned LOAD_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_SIZE];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [LOAD_W-1:0] count;
    logic [LOAD_W-1:0] count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    // Accept decisions use the registered flags only: no bypass, no fall-through.
    assign wr_acc = bus.wr & ~bus.full;
    assign rd_acc = bus.rd & ~bus.empty;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + LOAD_W'(1);
        end else if (!wr_acc && rd_acc) begin
            count_nxt = count - LOAD_W'(1);
        end
    end

    // Storage array kept reset-free so it maps onto simple dual-port RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            bus.full     <= 1'b0;
            bus.empty    <= 1'b1;
            bus.wr_load  <= '0;
            bus.rd_load  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rptr        <= rptr + PTR_W'(1);
                bus.rd_data <= mem[rptr];
            end
            count        <= count_nxt;
            bus.full     <= (count_nxt == LOAD_W'(FIFO_SIZE));
            bus.empty    <= (count_nxt == '0);
            bus.wr_load  <= count_nxt;
            bus.rd_load  <= count_nxt;
            bus.rd_valid <= rd_acc;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ovf <= 1'b0;
            bus.udf <= 1'b0;
        end else begin
            if (bus.wr && bus.full) begin
                bus.ovf <= 1'b1;
            end
            if (bus.rd && bus.empty) begin
                bus.udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ld.sv
// Directed bench for sync_fifo_ld at FIFO_SIZE=16 with hand-computed expectations.
module tb_sync_fifo_ld;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FIFO_SIZE = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sync_fifo_ld_if #(.DATA_W(DATA_W), .FIFO_SIZE(FIFO_SIZE)) bus ();

    sync_fifo_ld #(.DATA_W(DATA_W), .FIFO_SIZE(FIFO_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_empty(input string tag);
        check_eq({tag, ".empty"}, 64'(bus.empty), 64'd1);
        check_eq({tag, ".full"}, 64'(bus.full), 64'd0);
        check_eq({tag, ".wr_load"}, 64'(bus.wr_load), 64'd0);
        check_eq({tag, ".rd_load"}, 64'(bus.rd_load), 64'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.wr_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle_empty("idle");
            check_eq("idle.rd_valid", 64'(bus.rd_valid), 64'd0);
            check_eq("idle.rd_data", 64'(bus.rd_data), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check_eq("idle.ovf", 64'(bus.ovf), 64'd0);
            check_eq("idle.udf", 64'(bus.udf), 64'd0);
`endif
        end

        // Ten back-to-back writes then ten back-to-back reads.
        for (int i = 1; i <= 10; i++) begin
            bus.wr      = 1'b1;
            bus.wr_data = DATA_W'(i);
            tick();
            check_eq("seq.wr_load", 64'(bus.wr_load), 64'(i));
            check_eq("seq.empty", 64'(bus.empty), 64'd0);
        end
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        check_eq("seq.pre_valid", 64'(bus.rd_valid), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("seq.rd_valid", 64'(bus.rd_valid), 64'd1);
            check_eq("seq.rd_data", 64'(bus.rd_data), 64'(i));
            check_eq("seq.rd_load", 64'(bus.rd_load), 64'(10 - i));
        end
        bus.rd = 1'b0;
        tick();
        check_idle_empty("seq.end");
        check_eq("seq.end.rd_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("seq.end.rd_hold", 64'(bus.rd_data), 64'h0A);

        // Fill, then write while full is dropped.
        for (int i = 0; i < 16; i++) begin
            bus.wr      = 1'b1;
            bus.wr_data = DATA_W'(32'h100 + i);
            tick();
        end
        check_eq("fill.full", 64'(bus.full), 64'd1);
        check_eq("fill.wr_load", 64'(bus.wr_load), 64'd16);
        bus.wr_data = DATA_W'(32'hDEAD);
        tick();
        bus.wr = 1'b0;
        check_eq("ovf_wr.full", 64'(bus.full), 64'd1);
        check_eq("ovf_wr.rd_load", 64'(bus.rd_load), 64'd16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_eq("ovf_wr.ovf", 64'(bus.ovf), 64'd1);
`endif
        bus.rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("fill.drain_valid", 64'(bus.rd_valid), 64'd1);
            check_eq("fill.drain_data", 64'(bus.rd_data), 64'(32'h100 + i));
        end
        bus.rd = 1'b0;
        tick();
        check_idle_empty("fill.end");
        check_eq("fill.end.rd_valid", 64'(bus.rd_valid), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_eq("fill.end.udf", 64'(bus.udf), 64'd0);
`endif

        // Full with simultaneous write and read: read wins, write dropped.
        for (int i = 0; i < 16; i++) begin
            bus.wr      = 1'b1;
            bus.wr_data = DATA_W'(32'h200 + i);
            tick();
        end
        bus.wr_data = DATA_W'(32'hBEEF);
        bus.rd      = 1'b1;
        tick();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        check_eq("fullrw.rd_valid", 64'(bus.rd_valid), 64'd1);
        check_eq("fullrw.rd_data", 64'(bus.rd_data), 64'h200);
        check_eq("fullrw.load", 64'(bus.wr_load), 64'd15);
        check_eq("fullrw.full", 64'(bus.full), 64'd0);
        bus.rd = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            check_eq("fullrw.drain_data", 64'(bus.rd_data), 64'(32'h200 + i));
        end
        bus.rd = 1'b0;
        tick();
        check_idle_empty("fullrw.end");
        check_eq("fullrw.end.rd_valid", 64'(bus.rd_valid), 64'd0);

        // Half full streaming across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            bus.wr      = 1'b1;
            bus.wr_data = DATA_W'(32'h300 + i);
            tick();
        end
        bus.rd = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bus.wr_data = DATA_W'(32'h308 + k);
            tick();
            check_eq("stream.rd_valid", 64'(bus.rd_valid), 64'd1);
            check_eq("stream.rd_data", 64'(bus.rd_data), 64'(32'h300 + k));
            check_eq("stream.load", 64'(bus.rd_load), 64'd8);
        end
        bus.wr = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            check_eq("stream.drain_data", 64'(bus.rd_data), 64'(32'h300 + 100 + j));
        end
        bus.rd = 1'b0;
        tick();
        check_idle_empty("stream.end");

        // Empty with simultaneous write and read: no fall-through.
        bus.wr      = 1'b1;
        bus.wr_data = DATA_W'(32'h55);
        bus.rd      = 1'b1;
        tick();
        bus.wr = 1'b0;
        check_eq("emptyrw.rd_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("emptyrw.load", 64'(bus.rd_load), 64'd1);
        check_eq("emptyrw.empty", 64'(bus.empty), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_eq("emptyrw.udf", 64'(bus.udf), 64'd1);
`endif
        tick();
        bus.rd = 1'b0;
        check_eq("emptyrw.rd2_valid", 64'(bus.rd_valid), 64'd1);
        check_eq("emptyrw.rd2_data", 64'(bus.rd_data), 64'h55);
        tick();
        check_eq("emptyrw.hold_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("emptyrw.hold_data", 64'(bus.rd_data), 64'h55);

        // Reset mid-operation with 5 words stored and a read pending.
        for (int i = 0; i < 5; i++) begin
            bus.wr      = 1'b1;
            bus.wr_data = DATA_W'(32'h400 + i);
            tick();
        end
        bus.wr = 1'b0;
        check_eq("midrst.pre_load", 64'(bus.wr_load), 64'd5);
        rst    = 1'b1;
        bus.rd = 1'b1;
        tick();
        rst    = 1'b0;
        bus.rd = 1'b0;
        check_idle_empty("midrst");
        check_eq("midrst.rd_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("midrst.rd_data", 64'(bus.rd_data), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_eq("midrst.ovf", 64'(bus.ovf), 64'd0);
        check_eq("midrst.udf", 64'(bus.udf), 64'd0);
`endif
        tick();
        check_idle_empty("postrst");
        check_eq("postrst.rd_valid", 64'(bus.rd_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ld.md
Name: sync_fifo_ld

Overview:
- Single-clock synchronous FIFO implementing the device side of the FIFO port pair that the host/bench drives.
- Write side: wr / data / full / load. Read side: rd / data / valid / empty / load.
- Read data is registered and returned with a valid strobe one cycle after an accepted read.
- Used as the TX and RX buffers between the user logic and the FT245 protocol engine.

Parameters:
- DATA_W, 32, data word width in bits.
- FIFO_SIZE, 4096, depth in words; must be a power of 2 and ≥ 2.
- LOAD_W, $clog2(FIFO_SIZE)+1, width of load outputs; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- wr  input  1  write request.
- wr_data  input  DATA_W  write data, sampled when wr is high.
- full  output  1  FIFO holds FIFO_SIZE words.
- wr_load  output  LOAD_W  current word count as seen by the writer.
- rd  input  1  read request.
- rd_data  output  DATA_W  read data, qualified by rd_valid.
- rd_valid  output  1  rd_data holds a word popped the previous cycle.
- empty  output  1  FIFO holds 0 words.
- rd_load  output  LOAD_W  current word count as seen by the reader.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: empty=1, full=0, wr_load=0, rd_load=0, rd_valid=0, rd_data=0. Write and read pointers are 0. Memory contents are not reset.
- Reset mid-operation: all stored words are discarded. A read accepted in the reset cycle produces no rd_valid.
- Write accept: wr_acc = wr & ~full. The word is stored at wptr and wptr increments. Pointers are $clog2(FIFO_SIZE) bits and wrap naturally from FIFO_SIZE-1 to 0.
- Write while full: the write is dropped and no state changes, even if a read is accepted in the same cycle. full is a registered flag, not bypassed.
- Read accept: rd_acc = rd & ~empty. mem[rptr] is registered into rd_data, rd_valid=1 on the next cycle, and rptr increments.
- Read latency: exactly 1 cycle from accepted rd to rd_valid.
- Read while empty: ignored. rd_valid=0 next cycle. Applies even if a write is accepted in the same cycle; empty is registered, with no fall-through.
- rd_data when rd_valid=0: holds its last value.
- Back-to-back reads: rd held high yields a continuous rd_valid stream, one word per cycle, while data is available.
- Count, updated every cycle:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - unchanged when both or neither are accepted.
- Flags and loads:
  - full = (count == FIFO_SIZE).
  - empty = (count == 0).
  - Both are registered and update in the same cycle as count.
  - wr_load and rd_load both equal count; single clock domain, so no synchronisation offset.
- Write-to-read latency: a word written in cycle N gives empty=0 in cycle N+1. It can be read in N+1, so rd_valid appears in N+2.
- Ordering: strict FIFO. No word is lost except a write dropped while full.
- Memory: one write port and one registered read port, inferable as simple dual-port block RAM.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs ovf (1 bit) and udf (1 bit), both reset to 0 by rst.
  - ovf is set sticky on wr & full.
  - udf is set sticky on rd & empty.
  - Both are cleared only by rst.
- Not defined: the ports do not exist and the FIFO behaves identically otherwise.

Test Plan:
- Reset then idle, FIFO_SIZE=16: check empty=1, full=0, loads=0, rd_valid=0 for 5 cycles.
- Write 0x00000001..0x0000000A back-to-back, then hold rd for 10 cycles: wr_load steps 1..10. First rd_valid comes 1 cycle after first rd, then 10 consecutive valid words 0x1..0xA in order, then empty=1 and load=0.
- Fill 16 words, then assert wr with 0xDEAD: full=1, load=16, write dropped (ovf=1 if macro defined). Drain gives exactly the 16 original words.
- Full plus simultaneous wr and rd for 1 cycle: read accepted, write dropped, load=15, full=0.
- Half full (8 words), continuous wr and rd for 100 cycles with incrementing data: load stays 8 and output matches input sequence delayed 8 words. Covers pointer wrap-around.
- Empty plus simultaneous wr 0x55 and rd: no rd_valid next cycle, load=1. A rd in the following cycle returns 0x55 with rd_valid one cycle later. Assert rst while 5 words are stored: next cycle empty=1, load=0, rd_valid=0.
